// File: rtl/tetris_line_clear_ctrl.sv
// tetris_line_clear_ctrl
// Compacts the playfield after a piece locks. It scans the row store from
// bottom to top, drops every full row and shifts the surviving rows down in a
// single pass. It then zero-fills the vacated top rows and reports the number
// of lines cleared. Running line and score totals are kept here as well.
// Optional feature macro: TETRIS_SCORE_EN. When it is defined, the score
// accumulates base[n] * (level + 1). When it is undefined, score reads 0.
module tetris_line_clear_ctrl #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        level,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] row_rd_addr,
    input  logic [COLS-1:0]   row_rd_data,
    output logic              row_wr_en,
    output logic [ADDR_W-1:0] row_wr_addr,
    output logic [COLS-1:0]   row_wr_data,
    output logic [2:0]        lines_cleared,
    output logic [15:0]       total_lines,
    output logic [19:0]       score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   n_reg, n_next;
    logic              row_full;

    logic [2:0]        lines_cleared_reg, lines_cleared_next;
    logic [15:0]       total_lines_reg, total_lines_next;
    logic [16:0]       total_sum;
    logic [19:0]       score_reg, score_next;

    assign row_full = &row_rd_data;

    // Control state: FSM state, read/write row pointers, and the count of full rows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            rd_ptr_reg <= LAST_ROW;
            wr_ptr_reg <= LAST_ROW;
            n_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            n_reg      <= n_next;
        end
    end

    // Next-state logic and row-port drive. Ports are 0 unless the state uses them.
    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        n_next      = n_reg;
        busy        = (state_reg != IDLE);
        done        = 1'b0;
        row_rd_addr = '0;
        row_wr_en   = 1'b0;
        row_wr_addr = '0;
        row_wr_data = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SCAN;
                    rd_ptr_next = LAST_ROW;
                    wr_ptr_next = LAST_ROW;
                    n_next      = '0;
                end
            end
            SCAN: begin
                row_rd_addr = rd_ptr_reg;
                if (row_full) begin
                    n_next = n_reg + (ADDR_W + 1)'(1);
                end else begin
                    // A row already in place needs no write. This holds until the first full row.
                    if (wr_ptr_reg != rd_ptr_reg) begin
                        row_wr_en   = 1'b1;
                        row_wr_addr = wr_ptr_reg;
                        row_wr_data = row_rd_data;
                    end
                    wr_ptr_next = wr_ptr_reg - ADDR_W'(1);
                end
                if (rd_ptr_reg == '0) begin
                    state_next = (n_next != '0) ? FILL : DONE;
                end else begin
                    rd_ptr_next = rd_ptr_reg - ADDR_W'(1);
                end
            end
            FILL: begin
                // wr_ptr enters FILL at n-1, so this state zeros exactly n top rows.
                row_wr_en   = 1'b1;
                row_wr_addr = wr_ptr_reg;
                row_wr_data = '0;
                wr_ptr_next = wr_ptr_reg - ADDR_W'(1);
                if (wr_ptr_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating statistics, updated once per pass while in DONE.
    always_comb begin
        lines_cleared_next = lines_cleared_reg;
        total_lines_next   = total_lines_reg;
        total_sum          = {1'b0, total_lines_reg} + 17'(n_reg);
        if (state_reg == DONE) begin
            lines_cleared_next = (n_reg > (ADDR_W + 1)'(7)) ? 3'd7 : n_reg[2:0];
            total_lines_next   = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

`ifdef TETRIS_SCORE_EN
    logic [10:0] base_pts;
    logic [15:0] pts;
    logic [20:0] score_sum;

    // Points for this pass: base[n] * (level+1), added to the score with saturation.
    always_comb begin
        case (n_reg)
            (ADDR_W + 1)'(0): base_pts = 11'd0;
            (ADDR_W + 1)'(1): base_pts = 11'd40;
            (ADDR_W + 1)'(2): base_pts = 11'd100;
            (ADDR_W + 1)'(3): base_pts = 11'd300;
            default:          base_pts = 11'd1200;
        endcase
        pts        = 16'(base_pts) * 16'({1'b0, level} + 5'd1);
        score_sum  = {1'b0, score_reg} + 21'(pts);
        score_next = score_reg;
        if (state_reg == DONE) begin
            score_next = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        end
    end
`else
    logic unused_level;

    // Scoring is compiled out, so level has no effect here.
    always_comb begin
        unused_level = ^level;
        score_next   = '0;
    end
`endif

    // Statistic registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lines_cleared_reg <= '0;
            total_lines_reg   <= '0;
            score_reg         <= '0;
        end else begin
            lines_cleared_reg <= lines_cleared_next;
            total_lines_reg   <= total_lines_next;
            score_reg         <= score_next;
        end
    end

    assign lines_cleared = lines_cleared_reg;
    assign total_lines   = total_lines_reg;
    assign score         = score_reg;

endmodule

// File: tb/tb_tetris_line_clear_ctrl.sv
// Directed testbench for tetris_line_clear_ctrl, with a behavioural row store.
module tb_tetris_line_clear_ctrl;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [3:0]        level;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] row_rd_addr;
    logic [COLS-1:0]   row_rd_data;
    logic              row_wr_en;
    logic [ADDR_W-1:0] row_wr_addr;
    logic [COLS-1:0]   row_wr_data;
    logic [2:0]        lines_cleared;
    logic [15:0]       total_lines;
    logic [19:0]       score;

    logic [COLS-1:0] mem      [0:31];
    logic [COLS-1:0] orig     [0:ROWS-1];
    logic [COLS-1:0] exp_grid [0:ROWS-1];

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_count     = 0;
    int last_wr_addr = 0;
    int last_wr_data = 0;
    int done_cycle;
    int done_count;
    int exp_total;
    int exp_score;

    tetris_line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .level        (level),
        .busy         (busy),
        .done         (done),
        .row_rd_addr  (row_rd_addr),
        .row_rd_data  (row_rd_data),
        .row_wr_en    (row_wr_en),
        .row_wr_addr  (row_wr_addr),
        .row_wr_data  (row_wr_data),
        .lines_cleared(lines_cleared),
        .total_lines  (total_lines),
        .score        (score)
    );

    always #5 clk = ~clk;

    assign row_rd_data = mem[row_rd_addr];

    always @(posedge clk) begin
        if (row_wr_en) begin
            mem[row_wr_addr] <= row_wr_data;
            wr_count     = wr_count + 1;
            last_wr_addr = int'(row_wr_addr);
            last_wr_data = int'(row_wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    function automatic int pts(input int v);
`ifdef TETRIS_SCORE_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Random contents that are never a full row.
    task automatic rand_grid();
        for (int r = 0; r < ROWS; r++) orig[r] = COLS'($urandom_range(0, 10'h3FE));
    endtask

    task automatic load_grid();
        @(negedge clk);
        for (int r = 0; r < ROWS; r++) mem[r] = orig[r];
    endtask

    function automatic int grid_mismatch();
        int cnt = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_grid[r]) cnt++;
        return cnt;
    endfunction

    // Raise start for one cycle, then run until done, plus five cycles to catch a second done.
    task automatic run_pass(input int pulse_at);
        done_cycle = -1;
        done_count = 0;
        wr_count   = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = (c == pulse_at);
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0 && c >= done_cycle + 5) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_total = 0;
        exp_score = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mem[r] = '0;
        reset_n   = 1'b0;
        start     = 1'b0;
        level     = 4'd0;
        exp_total = 0;
        exp_score = 0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(row_wr_en), 0);
        check("rst_lines", 32'(lines_cleared), 0);
        check("rst_total", 32'(total_lines), 0);
        check("rst_score", 32'(score), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // No full rows: nothing is written and the grid is unchanged.
        rand_grid();
        for (int r = 0; r < ROWS; r++) exp_grid[r] = orig[r];
        load_grid();
        run_pass(0);
        check("t1_done_cycle", 32'(done_cycle), 21);
        check("t1_writes", 32'(wr_count), 0);
        check("t1_lines", 32'(lines_cleared), 0);
        check("t1_grid", 32'(grid_mismatch()), 0);
        check("t1_busy_after", 32'(busy), 0);

        // Bottom row is full.
        rand_grid();
        orig[19] = 10'h3FF;
        orig[18] = 10'h001;
        exp_grid[19] = 10'h001;
        for (int r = 1; r <= 18; r++) exp_grid[r] = orig[r-1];
        exp_grid[0] = '0;
        load_grid();
        run_pass(0);
        exp_total += 1;
        exp_score += pts(40);
        check("t2_done_cycle", 32'(done_cycle), 22);
        check("t2_lines", 32'(lines_cleared), 1);
        check("t2_grid", 32'(grid_mismatch()), 0);
        check("t2_total", 32'(total_lines), 32'(exp_total));
        check("t2_score", 32'(score), 32'(exp_score));

        // Rows 19 and 17 are full, with a survivor between them.
        rand_grid();
        orig[19] = 10'h3FF;
        orig[18] = 10'h2AA;
        orig[17] = 10'h3FF;
        orig[16] = 10'h155;
        exp_grid[19] = 10'h2AA;
        exp_grid[18] = 10'h155;
        for (int r = 2; r <= 17; r++) exp_grid[r] = orig[r-2];
        exp_grid[1] = '0;
        exp_grid[0] = '0;
        load_grid();
        run_pass(0);
        exp_total += 2;
        exp_score += pts(100);
        check("t3_done_cycle", 32'(done_cycle), 23);
        check("t3_lines", 32'(lines_cleared), 2);
        check("t3_grid", 32'(grid_mismatch()), 0);
        check("t3_total", 32'(total_lines), 32'(exp_total));
        check("t3_score", 32'(score), 32'(exp_score));

        // Four rows are cleared at level 2, starting from fresh totals.
        do_reset();
        level = 4'd2;
        rand_grid();
        for (int r = 16; r <= 19; r++) orig[r] = 10'h3FF;
        for (int r = 4; r <= 19; r++) exp_grid[r] = orig[r-4];
        for (int r = 0; r < 4; r++) exp_grid[r] = '0;
        load_grid();
        run_pass(0);
        exp_total += 4;
        exp_score += pts(3600);
        check("t4_done_cycle", 32'(done_cycle), 25);
        check("t4_lines", 32'(lines_cleared), 4);
        check("t4_grid", 32'(grid_mismatch()), 0);
        check("t4_total", 32'(total_lines), 32'(exp_total));
        check("t4_score", 32'(score), 32'(exp_score));
        level = 4'd0;

        // A start pulse in the middle of a pass is ignored.
        rand_grid();
        load_grid();
        run_pass(5);
        check("t5_done_count", 32'(done_count), 1);
        check("t5_done_cycle", 32'(done_cycle), 21);
        check("t5_busy_after", 32'(busy), 0);

        // A reset in the middle of a pass clears all outputs at once.
        rand_grid();
        orig[19] = 10'h3FF;
        load_grid();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("t6_busy_mid", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_wr_en", 32'(row_wr_en), 0);
        check("t6_rst_total", 32'(total_lines), 0);
        check("t6_rst_score", 32'(score), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_total = 0;
        exp_score = 0;

        // Only row 0 is full: the single write is the FILL write of zeros.
        rand_grid();
        orig[0] = 10'h3FF;
        for (int r = 0; r < ROWS; r++) exp_grid[r] = orig[r];
        exp_grid[0] = '0;
        load_grid();
        run_pass(0);
        exp_total += 1;
        exp_score += pts(40);
        check("t7_done_cycle", 32'(done_cycle), 22);
        check("t7_writes", 32'(wr_count), 1);
        check("t7_wr_addr", 32'(last_wr_addr), 0);
        check("t7_wr_data", 32'(last_wr_data), 0);
        check("t7_lines", 32'(lines_cleared), 1);
        check("t7_grid", 32'(grid_mismatch()), 0);
        check("t7_total", 32'(total_lines), 32'(exp_total));

        // Every row is full: the whole grid is zeroed and lines_cleared saturates.
        for (int r = 0; r < ROWS; r++) begin
            orig[r]     = 10'h3FF;
            exp_grid[r] = '0;
        end
        load_grid();
        run_pass(0);
        exp_total += 20;
        exp_score += pts(1200);
        check("t8_done_cycle", 32'(done_cycle), 41);
        check("t8_writes", 32'(wr_count), 20);
        check("t8_lines", 32'(lines_cleared), 7);
        check("t8_grid", 32'(grid_mismatch()), 0);
        check("t8_total", 32'(total_lines), 32'(exp_total));
        check("t8_score", 32'(score), 32'(exp_score));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
